// File: rtl/turbo_pkg.sv
// Shared turbo decoder definitions: scheduler state encoding, default sizing
// and SISO handshake constants reused by the decoder top level.
package turbo_pkg;

    localparam int unsigned TURBO_MAX_ITER   = 16;
    localparam int unsigned TURBO_ITER_W     = 6;
    localparam int unsigned TURBO_LOAD_BEATS = 4;
    localparam int unsigned TURBO_TIMEOUT    = 255;
    localparam int unsigned TURBO_TO_W       = 8;

    // Width of the load beat index port; supports up to 8 beats per block.
    localparam int unsigned TURBO_BEAT_W     = 3;

    // SISO handshake: start is a single-cycle pulse, done may be pulse or level.
    localparam int unsigned SISO_START_CYCLES = 1;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LOAD    = 4'd1,
        ST_D1_GO   = 4'd2,
        ST_D1_WAIT = 4'd3,
        ST_D2_GO   = 4'd4,
        ST_D2_WAIT = 4'd5,
        ST_CHECK   = 4'd6,
        ST_OUT     = 4'd7,
        ST_ERR     = 4'd8
    } sched_state_e;

    function automatic logic is_siso1_phase(input sched_state_e s);
        return (s == ST_D1_GO) || (s == ST_D1_WAIT);
    endfunction

endpackage

// File: rtl/siso_watchdog.sv
// Cycle watchdog shared by both SISO wait states; expire_o flags the wait
// cycle in which the count reaches TIMEOUT without being cleared.
module siso_watchdog #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic clk_p_i,
    input  logic reset_n_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Expiry is raised in the cycle whose increment would reach TIMEOUT.
    assign expire_o = enable_i && !clear_i && (cnt_q == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/turbo_iter_sched.sv
// Turbo decoder iteration scheduler: block load, alternating SISO1/SISO2
// half-iterations, iteration counting, early termination and output handoff.
module turbo_iter_sched
    import turbo_pkg::*;
#(
    parameter int unsigned MAX_ITER   = TURBO_MAX_ITER,
    parameter int unsigned ITER_W     = TURBO_ITER_W,
    parameter int unsigned LOAD_BEATS = TURBO_LOAD_BEATS,
    parameter int unsigned TIMEOUT    = TURBO_TIMEOUT,
    parameter int unsigned TO_W       = TURBO_TO_W
) (
    input  logic                    clk_p_i,
    input  logic                    reset_n_i,
    input  logic                    start_i,
    input  logic                    load_valid_i,
    output logic                    load_ready_o,
    output logic [TURBO_BEAT_W-1:0] load_beat_o,
    output logic                    siso1_start_o,
    input  logic                    siso1_done_i,
    output logic                    siso2_start_o,
    input  logic                    siso2_done_i,
    output logic                    ext_zero_o,
    input  logic                    early_en_i,
    input  logic                    hd_equal_i,
    output logic [ITER_W-1:0]       iter_o,
    output logic                    out_valid_o,
    input  logic                    out_ack_i,
    output logic                    busy_o,
    output logic                    err_o
);

    sched_state_e            state_q;
    sched_state_e            state_d;
    logic [ITER_W-1:0]       iter_q;
    logic [ITER_W-1:0]       iter_d;
    logic [TURBO_BEAT_W-1:0] beat_q;
    logic [TURBO_BEAT_W-1:0] beat_d;

    logic                    wd_clear;
    logic                    wd_enable;
    logic                    wd_expire;
    logic [ITER_W-1:0]       iter_inc;
    logic                    last_beat;
    logic                    early_stop;

    assign iter_inc   = iter_q + ITER_W'(1);
    assign last_beat  = (beat_q == TURBO_BEAT_W'(LOAD_BEATS - 1));
    // First iteration is never a candidate: there is no previous decision yet.
    assign early_stop = early_en_i && hd_equal_i && (iter_q != '0);

    siso_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clk_p_i   (clk_p_i),
        .reset_n_i (reset_n_i),
        .clear_i   (wd_clear),
        .enable_i  (wd_enable),
        .expire_o  (wd_expire)
    );

    always_comb begin
        state_d       = state_q;
        iter_d        = iter_q;
        beat_d        = beat_q;
        wd_clear      = 1'b0;
        wd_enable     = 1'b0;
        load_ready_o  = 1'b0;
        siso1_start_o = 1'b0;
        siso2_start_o = 1'b0;
        out_valid_o   = 1'b0;
        err_o         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_LOAD;
                    iter_d   = '0;
                    beat_d   = '0;
                    wd_clear = 1'b1;
                end
            end

            ST_LOAD: begin
                load_ready_o = 1'b1;
                if (load_valid_i) begin
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = ST_D1_GO;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end

            ST_D1_GO: begin
                siso1_start_o = 1'b1;
                wd_clear      = 1'b1;
                state_d       = ST_D1_WAIT;
            end

            ST_D1_WAIT: begin
                wd_enable = !siso1_done_i;
                if (siso1_done_i) begin
                    state_d = ST_D2_GO;
                end else if (wd_expire) begin
                    state_d = ST_ERR;
                end
            end

            ST_D2_GO: begin
                siso2_start_o = 1'b1;
                wd_clear      = 1'b1;
                state_d       = ST_D2_WAIT;
            end

            ST_D2_WAIT: begin
                wd_enable = !siso2_done_i;
                if (siso2_done_i) begin
                    state_d = ST_CHECK;
                end else if (wd_expire) begin
                    state_d = ST_ERR;
                end
            end

            ST_CHECK: begin
                iter_d = iter_inc;
                if ((iter_inc == ITER_W'(MAX_ITER)) || early_stop) begin
                    state_d = ST_OUT;
                end else begin
                    state_d = ST_D1_GO;
                end
            end

            ST_OUT: begin
                out_valid_o = 1'b1;
                if (out_ack_i) begin
                    state_d = ST_IDLE;
                end
            end

            ST_ERR: begin
                err_o = 1'b1;
                if (start_i) begin
                    state_d  = ST_LOAD;
                    iter_d   = '0;
                    beat_d   = '0;
                    wd_clear = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign ext_zero_o  = is_siso1_phase(state_q) && (iter_q == '0);
    assign iter_o      = iter_q;
    assign load_beat_o = beat_q;

    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            iter_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            beat_q  <= beat_d;
        end
    end

endmodule

// File: doc/turbo_iter_sched.md
Name: turbo_iter_sched

Overview:
Iteration scheduler for the turbo decoder datapath. It sequences one code block through a load phase and then alternates SISO1/SISO2 half-iterations using start-pulse/done handshakes. It counts iterations, applies optional early termination, and presents decoded-output-valid to the output stage. It sits between the input reader, the two SISO instances with their interleaver network, and the hard-decision output logic.

Parameters:
MAX_ITER, 16, maximum full iterations (SISO1+SISO2); legal range 1..2^ITER_W-1
ITER_W, 6, width of the iteration counter
LOAD_BEATS, 4, input beats per code block; legal range 1..8
TIMEOUT, 255, max cycles in a SISO wait state before error; legal range 1..2^TO_W-1
TO_W, 8, watchdog counter width

Ports:
clk_p_i  in  1  clock, rising edge
reset_n_i  in  1  asynchronous active-low reset
start_i  in  1  request to decode a new block; sampled in IDLE and ERR only
load_valid_i  in  1  one input beat transferred this cycle (counts only when load_ready_o=1)
load_ready_o  out  1  scheduler is accepting input beats
load_beat_o  out  3  index of the beat being written (0..LOAD_BEATS-1)
siso1_start_o  out  1  one-cycle start pulse to SISO1
siso1_done_i  in  1  SISO1 finished (pulse or level)
siso2_start_o  out  1  one-cycle start pulse to SISO2
siso2_done_i  in  1  SISO2 finished
ext_zero_o  out  1  force SISO1 extrinsic input to zero (first iteration)
early_en_i  in  1  enable early termination
hd_equal_i  in  1  hard decisions of this iteration equal the previous iteration's
iter_o  out  ITER_W  completed-iteration count
out_valid_o  out  1  decoded block ready
out_ack_i  in  1  output stage consumed the block
busy_o  out  1  scheduler is not in IDLE
err_o  out  1  SISO watchdog expired; sticky

Behaviour:
- Reset values: state IDLE. All outputs 0. iter_o=0, load_beat_o=0, watchdog=0, err_o=0.
- Reset is asynchronous; assertion mid-operation aborts the block immediately. No pulse is emitted on reset release.
- FSM states: IDLE, LOAD, D1_GO, D1_WAIT, D2_GO, D2_WAIT, CHECK, OUT, ERR.
- IDLE: on start_i -> LOAD; clear iter_o, load_beat_o and watchdog.
- LOAD: load_ready_o=1. Each load_valid_i increments load_beat_o. The beat with index LOAD_BEATS-1 -> D1_GO next cycle, and load_beat_o returns to 0.
- D1_GO: siso1_start_o=1 for exactly this cycle; clear watchdog; -> D1_WAIT. Any done input seen in a GO state is stale and ignored.
- D1_WAIT: siso1_done_i -> D2_GO. Otherwise the watchdog increments; when watchdog==TIMEOUT with no done -> ERR. If done and expiry coincide, done wins.
- ext_zero_o=1 in D1_GO and D1_WAIT while iter_o==0; 0 otherwise.
- D2_GO and D2_WAIT mirror D1 using siso2_start_o and siso2_done_i. Done -> CHECK.
- CHECK (one cycle): iter_o <= iter_o+1. Go to OUT if iter_o+1==MAX_ITER, or if early_en_i && hd_equal_i && iter_o>=1. Otherwise -> D1_GO.
  - Early stop is never taken on the first iteration.
- OUT: out_valid_o=1, held until out_ack_i; ack -> IDLE. iter_o holds its final count until the next start.
  - Ack in the same cycle valid first rises is legal, giving one cycle in OUT.
- ERR: err_o=1 and busy_o=1. start_i clears err_o and -> LOAD (same as IDLE start).
- busy_o=1 in every state except IDLE.
- start_i outside IDLE/ERR is ignored; no queuing.
- Latency: start to first siso1_start_o = LOAD_BEATS+1 cycles with back-to-back beats. Per iteration overhead = 3 cycles plus the two SISO latencies.
- Counters saturate nowhere; legal parameter ranges guarantee no wrap.

Decomposition:
- Shared package turbo_pkg holds the FSM state encoding, MAX_ITER, ITER_W, LOAD_BEATS and the SISO handshake constants, so the decoder top can reuse them.
- One natural sub-module: siso_watchdog (clear, enable, expire output). It is instantiated once and shared by both wait states, since only one wait state is active at a time.

Test Plan:
- Reset mid-D1_WAIT with iter_o=3 -> all outputs 0 in the same cycle; state IDLE after release; no start pulse.
- MAX_ITER=2, early_en_i=0, start + 4 back-to-back beats, SISO done 5 cycles after each start:
  - siso1_start_o first pulses in cycle 5 after start.
  - Pulse order is S1,S2,S1,S2.
  - ext_zero_o=1 only during the first SISO1 phase.
  - out_valid_o asserts with iter_o=2.
- Early stop: early_en_i=1, hd_equal_i=1 from the start -> termination at the CHECK where iter_o becomes 2, not 1; out_valid_o with iter_o=2.
- Watchdog: TIMEOUT=10, siso2_done_i never asserts -> err_o=1 exactly 10 cycles after D2_WAIT entry; start_i clears err_o and restarts LOAD.
- Done coinciding with watchdog expiry -> no error; advance to the next state. Done asserted during the GO cycle -> ignored; FSM waits for a fresh done.
- Hold out_ack_i=0 for 20 cycles, pulse start_i in OUT -> out_valid_o held, start ignored; ack -> IDLE, busy_o=0 next cycle.
